// File: rtl/gt1_loader_pkg.sv
// gt1_loader shared types and constants.
// GT1 image parser states and grammar values.
package gt1_loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SEG_HI,
    S_SEG_LO,
    S_SEG_SIZE,
    S_DATA,
    S_WR_WAIT,
    S_START_HI,
    S_START_LO,
    S_DONE,
    S_ERR
  } gt1_state_e;

  localparam int         GT1_PAGE_BYTES = 256;
  localparam logic [7:0] GT1_TERMINATOR = 8'h00;

endpackage

// File: rtl/gt1_loader.sv
// GT1 image loader: parses the ioctl byte stream into
// single-byte Gigatron RAM writes and reports the start address.
module gt1_loader
  import gt1_loader_pkg::*;
#(
  parameter logic [7:0] INDEX = 8'd1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic        ioctl_wait,
  output logic        ram_wr_req,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_data,
  input  logic        ram_wr_ack,
  output logic        exec_valid,
  output logic [15:0] exec_addr,
  output logic        busy,
  output logic        error
);

  localparam logic [8:0] PAGE9 = 9'(GT1_PAGE_BYTES);

  gt1_state_e  state_q;
  logic        dl_q;
  logic        first_q;
  logic [24:0] off_q;
  logic [7:0]  page_q;
  logic [7:0]  lo_q;
  logic [8:0]  rem_q;
  logic        req_q;
  logic        wait_q;
  logic [15:0] addr_q;
  logic [7:0]  data_q;
  logic        ev_q;
  logic [15:0] exec_q;
  logic        err_q;

  logic idx_ok;
  logic acc;
  logic rise;
  logic fall;
  logic parse;
  logic busy_w;
  logic err_hit;

  assign idx_ok = ioctl_index == INDEX;
  assign acc    = ioctl_download & ioctl_wr & idx_ok;
  assign rise   = ioctl_download & ~dl_q;
  assign fall   = ~ioctl_download & dl_q;
  assign busy_w = !(state_q inside {S_IDLE, S_DONE, S_ERR});
  assign parse  = busy_w & (state_q != S_WR_WAIT);

  // Truncation, overrun and offset gaps all abandon the image.
  assign err_hit = (fall & busy_w)
                 | (acc & (state_q == S_WR_WAIT))
                 | (acc & parse & (ioctl_addr != off_q));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      dl_q    <= 1'b0;
      first_q <= 1'b0;
      off_q   <= '0;
      page_q  <= '0;
      lo_q    <= '0;
      rem_q   <= '0;
      req_q   <= 1'b0;
      wait_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ev_q    <= 1'b0;
      exec_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      dl_q <= ioctl_download;
      ev_q <= 1'b0;
      if (err_hit) begin
        state_q <= S_ERR;
        err_q   <= 1'b1;
        req_q   <= 1'b0;
        wait_q  <= 1'b0;
      end else begin
        if (acc && parse) off_q <= off_q + 25'd1;
        unique case (state_q)
          S_IDLE, S_ERR: begin
            if (rise && idx_ok) begin
              state_q <= S_SEG_HI;
              err_q   <= 1'b0;
              first_q <= 1'b1;
              off_q   <= '0;
            end
          end
          S_SEG_HI: begin
            if (acc) begin
              if (ioctl_dout != GT1_TERMINATOR || first_q) begin
                page_q  <= ioctl_dout;
                state_q <= S_SEG_LO;
              end else begin
                state_q <= S_START_HI;
              end
            end
          end
          S_SEG_LO: begin
            if (acc) begin
              lo_q    <= ioctl_dout;
              state_q <= S_SEG_SIZE;
            end
          end
          S_SEG_SIZE: begin
            if (acc) begin
              rem_q   <= (ioctl_dout == 8'd0) ? PAGE9 : {1'b0, ioctl_dout};
              first_q <= 1'b0;
              state_q <= S_DATA;
            end
          end
          S_DATA: begin
            if (acc) begin
              addr_q  <= {page_q, lo_q};
              data_q  <= ioctl_dout;
              req_q   <= 1'b1;
              wait_q  <= 1'b1;
              lo_q    <= lo_q + 8'd1;
              state_q <= S_WR_WAIT;
            end
          end
          S_WR_WAIT: begin
            if (ram_wr_ack) begin
              req_q   <= 1'b0;
              wait_q  <= 1'b0;
              rem_q   <= rem_q - 9'd1;
              state_q <= (rem_q == 9'd1) ? S_SEG_HI : S_DATA;
            end
          end
          S_START_HI: begin
            if (acc) begin
              exec_q[15:8] <= ioctl_dout;
              state_q      <= S_START_LO;
            end
          end
          S_START_LO: begin
            if (acc) begin
              exec_q[7:0] <= ioctl_dout;
              ev_q        <= 1'b1;
              state_q     <= S_DONE;
            end
          end
          S_DONE: begin
            if (fall) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign ioctl_wait = wait_q;
  assign ram_wr_req = req_q;
  assign ram_addr   = addr_q;
  assign ram_data   = data_q;
  assign exec_valid = ev_q;
  assign exec_addr  = exec_q;
  assign busy       = busy_w;
  assign error      = err_q;

endmodule

// File: tb/tb_gt1_loader.sv
// Scoreboard bench for gt1_loader: expected writes and
// start addresses are queued by stimulus, popped by a monitor.
module tb_gt1_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [7:0]  ioctl_index = 8'd1;
  logic        ioctl_wait;
  logic        ram_wr_req;
  logic [15:0] ram_addr;
  logic [7:0]  ram_data;
  logic        ram_wr_ack = 1'b0;
  logic        exec_valid;
  logic [15:0] exec_addr;
  logic        busy;
  logic        error;

  gt1_loader #(.INDEX(8'd1)) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout),
    .ioctl_index(ioctl_index),
    .ioctl_wait(ioctl_wait),
    .ram_wr_req(ram_wr_req),
    .ram_addr(ram_addr),
    .ram_data(ram_data),
    .ram_wr_ack(ram_wr_ack),
    .exec_valid(exec_valid),
    .exec_addr(exec_addr),
    .busy(busy),
    .error(error)
  );

  always #5 clk_sys = ~clk_sys;

  int          total = 0;
  int          bad = 0;
  int          exec_cnt = 0;
  logic [23:0] wq[$];
  logic [15:0] eq[$];
  logic [24:0] off = '0;
  int          ack_delay = 0;
  bit          ack_rand = 1'b0;
  bit          req_p = 1'b0;
  bit          ev_p = 1'b0;
  logic [23:0] cap = '0;
  bit          watch = 1'b0;
  bit          toggled = 1'b0;
  logic [44:0] snap = '0;
  logic [44:0] outs;

  assign outs = {ioctl_wait, ram_wr_req, ram_addr, ram_data,
                 exec_valid, exec_addr, busy, error};

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endfunction

  // Write acknowledger with fixed or random latency.
  initial begin
    int d;
    forever begin
      @(posedge clk_sys); #1;
      if (ram_wr_req) begin
        d = ack_rand ? int'($urandom_range(0, 5)) : ack_delay;
        repeat (d) @(posedge clk_sys);
        #1 ram_wr_ack = 1'b1;
        @(posedge clk_sys); #1;
        ram_wr_ack = 1'b0;
      end
    end
  end

  // Monitor
  always @(negedge clk_sys) begin
    if (reset_n) begin
      chk("wait_eq_req", {31'd0, ioctl_wait}, {31'd0, ram_wr_req});
      if (ram_wr_req && !req_p) begin
        if (wq.size() == 0) begin
          chk("wr_pending", 32'(wq.size()), 32'd1);
        end else begin
          chk("wr", {8'd0, ram_addr, ram_data}, {8'd0, wq.pop_front()});
        end
        cap = {ram_addr, ram_data};
      end else if (ram_wr_req) begin
        chk("wr_stable", {8'd0, ram_addr, ram_data}, {8'd0, cap});
      end
      if (exec_valid) begin
        exec_cnt++;
        chk("ev_width", {31'd0, ev_p}, 32'd0);
        if (eq.size() == 0)
          chk("ev_pending", 32'(eq.size()), 32'd1);
        else
          chk("exec_addr", {16'd0, exec_addr}, {16'd0, eq.pop_front()});
      end
      if (watch && outs != snap) toggled = 1'b1;
      req_p = ram_wr_req;
      ev_p  = exec_valid;
    end else begin
      req_p = 1'b0;
      ev_p  = 1'b0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic pulse(input logic [7:0] b);
    ioctl_addr = off;
    ioctl_dout = b;
    ioctl_wr   = 1'b1;
    cyc(1);
    ioctl_wr   = 1'b0;
    off        = off + 25'd1;
  endtask

  task automatic wait_rel();
    int k = 0;
    while (ioctl_wait && k < 60) begin
      cyc(1);
      k++;
    end
    if (ioctl_wait) chk("wait_timeout", {31'd0, ioctl_wait}, 32'd0);
  endtask

  task automatic send(input logic [7:0] b);
    pulse(b);
    wait_rel();
  endtask

  task automatic dat(input logic [7:0] pg, input logic [7:0] lo,
                     input logic [7:0] b);
    wq.push_back({pg, lo, b});
    send(b);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    off            = '0;
    cyc(2);
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    cyc(3);
  endtask

  task automatic finish_test(input string nm, input int ev_exp,
                             input logic err_exp);
    chk({nm, "_ev_cnt"}, 32'(exec_cnt), 32'(ev_exp));
    chk({nm, "_error"}, {31'd0, error}, {31'd0, err_exp});
    chk({nm, "_wq_left"}, 32'(wq.size()), 32'd0);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    wq.delete();
    eq.delete();
    exec_cnt = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    cyc(2);
    chk("reset_outs", {19'd0, outs[44:32]}, 32'd0);
    chk("reset_outs_lo", outs[31:0], 32'd0);
    reset_n = 1'b1;
    cyc(2);

    // T1: single segment
    ack_delay = 0;
    start_dl(8'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    send(8'h00); send(8'h88); send(8'h03);
    wq.push_back(24'h0088AA);
    pulse(8'hAA);
    chk("t1_req_lat", {30'd0, ram_wr_req, ioctl_wait}, 32'd3);
    wait_rel();
    dat(8'h00, 8'h89, 8'hBB);
    dat(8'h00, 8'h8A, 8'hCC);
    send(8'h00); send(8'h02);
    eq.push_back(16'h0200);
    pulse(8'h00);
    chk("t1_ev_lat", {31'd0, exec_valid}, 32'd1);
    cyc(1);
    chk("t1_ev_one", {31'd0, exec_valid}, 32'd0);
    end_dl();
    chk("t1_exec_addr", {16'd0, exec_addr}, 32'h0200);
    finish_test("t1", 1, 1'b0);

    // T2: 256-byte segment wrapping inside page 03, random ack
    ack_rand = 1'b1;
    start_dl(8'd1);
    send(8'h03); send(8'hF0); send(8'h00);
    for (int i = 0; i < 256; i++)
      dat(8'h03, 8'(8'hF0 + i), 8'(i) ^ 8'h5A);
    send(8'h00); send(8'h45);
    eq.push_back(16'h4567);
    send(8'h67);
    end_dl();
    chk("t2_exec_addr", {16'd0, exec_addr}, 32'h4567);
    finish_test("t2", 1, 1'b0);
    ack_rand = 1'b0;

    // T4: truncation in DATA with 2 bytes left
    start_dl(8'd1);
    send(8'h05); send(8'h00); send(8'h04);
    dat(8'h05, 8'h00, 8'h11);
    dat(8'h05, 8'h01, 8'h22);
    end_dl();
    cyc(5);
    finish_test("t4", 0, 1'b1);

    // T3: multi-segment from ERR, zero page first
    start_dl(8'd1);
    chk("t3_err_clr", {31'd0, error}, 32'd0);
    send(8'h00); send(8'h10); send(8'h02);
    dat(8'h00, 8'h10, 8'hD0);
    dat(8'h00, 8'h11, 8'hD1);
    send(8'h80); send(8'hFE); send(8'h03);
    dat(8'h80, 8'hFE, 8'hE0);
    dat(8'h80, 8'hFF, 8'hE1);
    dat(8'h80, 8'h00, 8'hE2);
    send(8'h00); send(8'h12);
    eq.push_back(16'h1234);
    send(8'h34);
    end_dl();
    chk("t3_exec_addr", {16'd0, exec_addr}, 32'h1234);
    finish_test("t3", 1, 1'b0);

    // T5: overrun during WR_WAIT
    ack_delay = 5;
    start_dl(8'd1);
    send(8'h01); send(8'h00); send(8'h02);
    wq.push_back(24'h010011);
    pulse(8'h11);
    pulse(8'h22);
    chk("t5_req_drop", {31'd0, ram_wr_req}, 32'd0);
    cyc(8);
    end_dl();
    finish_test("t5", 0, 1'b1);
    ack_delay = 0;

    // T6: offset gap 4 -> 6
    start_dl(8'd1);
    send(8'h07); send(8'h00); send(8'h03);
    dat(8'h07, 8'h00, 8'h31);
    dat(8'h07, 8'h01, 8'h32);
    off = 25'd6;
    pulse(8'h33);
    cyc(3);
    end_dl();
    finish_test("t6", 0, 1'b1);

    // T7: wrong index, outputs frozen
    snap    = outs;
    toggled = 1'b0;
    watch   = 1'b1;
    start_dl(8'd2);
    send(8'h00); send(8'h20); send(8'h01); send(8'h99);
    send(8'h00); send(8'h01); send(8'h02);
    end_dl();
    watch = 1'b0;
    chk("t7_no_toggle", {31'd0, toggled}, 32'd0);
    ioctl_index = 8'd1;
    wq.delete();
    eq.delete();
    exec_cnt = 0;

    // T8: reset mid-write, then clean parse
    ack_delay = 5;
    start_dl(8'd1);
    send(8'h02); send(8'h00); send(8'h02);
    wq.push_back(24'h020077);
    pulse(8'h77);
    cyc(1);
    chk("t8_req_before", {31'd0, ram_wr_req}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t8_rst_outs_hi", {19'd0, outs[44:32]}, 32'd0);
    chk("t8_rst_outs_lo", outs[31:0], 32'd0);
    ioctl_download = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    cyc(10);
    ack_delay = 0;
    chk("t8_wq_left", 32'(wq.size()), 32'd0);
    wq.delete();
    start_dl(8'd1);
    send(8'h01); send(8'h20); send(8'h01);
    dat(8'h01, 8'h20, 8'h5C);
    send(8'h00); send(8'hAB);
    eq.push_back(16'hABCD);
    send(8'hCD);
    end_dl();
    chk("t8_exec_addr", {16'd0, exec_addr}, 32'hABCD);
    finish_test("t8", 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gt1_loader.md
# gt1_loader

Upstream loader stage for the Gigatron core. It parses a GT1 program image streamed over the HPS `ioctl_*` download interface and turns it into single-byte write requests into Gigatron RAM, back-pressuring the HPS with `ioctl_wait` while each write is pending. When the image ends it reports the GT1 start address to the shell's launch logic, and it flags malformed or truncated images.

## Interface
**Parameters**
- `INDEX`, default 8'd1: value of `ioctl_index` that selects this loader. Any other index is ignored.

**Ports**
- `clk_sys`  in  1  system clock, shared with the `ioctl_*` bus.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ioctl_download`  in  1  download window.
- `ioctl_wr`  in  1  byte strobe, one cycle wide.
- `ioctl_addr`  in  25  byte offset within the file.
- `ioctl_dout`  in  8  byte data.
- `ioctl_index`  in  8  file type selector.
- `ioctl_wait`  out  1  stall request to the HPS.
- `ram_wr_req`  out  1  RAM write request, held until acknowledged.
- `ram_addr`  out  16  write address.
- `ram_data`  out  8  write data.
- `ram_wr_ack`  in  1  write accepted.
- `exec_valid`  out  1  one-cycle pulse: image complete.
- `exec_addr`  out  16  GT1 start address; valid from the `exec_valid` pulse onward.
- `busy`  out  1  parse in progress.
- `error`  out  1  sticky image error.

## Operation
- **Accepted byte:** `ioctl_download & ioctl_wr & (ioctl_index==INDEX)`.
- **GT1 grammar:** a sequence of segments, each `{hi, lo, size, data[size]}`.
  - `size==0` means 256 data bytes.
  - After the first segment, a `hi` byte of 0x00 is the terminator. It is followed by `start_hi` and `start_lo`.
  - In the first segment, a `hi` of 0x00 is a valid zero-page segment.
- **States:** IDLE, SEG_HI, SEG_LO, SEG_SIZE, DATA, WR_WAIT, START_HI, START_LO, DONE, ERR.
- **IDLE:** a rising edge of `ioctl_download` with a matching index goes to SEG_HI. It also clears `error`, sets `first_seg`, and clears the expected-offset counter.
- **SEG_HI:** byte ≠0, or `first_seg` set → latch page, go to SEG_LO. Otherwise (0x00 after the first segment) → START_HI.
- **SEG_LO:** latch the low address byte, go to SEG_SIZE.
- **SEG_SIZE:** load the 9-bit remaining count (0 → 256), clear `first_seg`, go to DATA.
- **DATA:**
  - Latch `ram_addr={page,lo}` and `ram_data`, set `ram_wr_req` and `ioctl_wait`, go to WR_WAIT.
  - `lo` increments mod 256 within the page; the page never carries.
- **WR_WAIT:** on `ram_wr_ack`, drop `ram_wr_req` and `ioctl_wait` and decrement remaining. Next state is SEG_HI if remaining reaches 0, otherwise DATA.
- **START_HI / START_LO:** latch `exec_addr[15:8]`, then `exec_addr[7:0]`. On the `start_lo` byte, pulse `exec_valid` and go to DONE.
- **DONE:** further accepted bytes are ignored. A falling edge of `ioctl_download` → IDLE.
- **Errors:** each of the following sets sticky `error` and goes to ERR.
  - `ioctl_addr` ≠ expected offset.
  - An accepted byte arriving while in WR_WAIT (overrun). The byte is dropped.
  - A falling edge of `ioctl_download` in any state other than IDLE or DONE (truncation).
- **ERR:** `ram_wr_req` and `ioctl_wait` are low and no further writes are issued. A new download start clears `error` and restarts the parse.
- **`busy`:** high in every state except IDLE, DONE and ERR.

## Timing
- **Reset values:** all outputs 0; state IDLE.
- **Reset mid-write:** `ram_wr_req` drops immediately (asynchronous); the partial image is abandoned.
- **Byte to write:** `ram_wr_req` and `ioctl_wait` rise on the clock edge that samples the accepted byte (1-cycle latency).
- **Ack to release:**
  - `ram_wr_ack` sampled high in cycle N → `ram_wr_req` and `ioctl_wait` low in cycle N+1.
  - An ack that is high in the same cycle `ram_wr_req` first rises is honoured on the next edge.
  - Minimum: 2 cycles per data byte.
- **`ram_addr` / `ram_data`:** stable for the whole time `ram_wr_req` is high.
- **`exec_valid`:** asserted in the cycle after `start_lo` is accepted, exactly one cycle wide.
- **Header bytes:** `hi`, `lo`, `size` and the start bytes never assert `ioctl_wait`.

## Structure
- Package `gt1_loader_pkg` holds:
  - the state enum;
  - `GT1_PAGE_BYTES=256`;
  - `GT1_TERMINATOR=8'h00`.
- Single module, no sub-modules.
- Download edge detection uses a registered copy of `ioctl_download` inside this module.

## Test plan
- **Single segment:** image `00 88 03 AA BB CC 00 02 00` (start_hi=02, start_lo=00), ack fixed at 1 cycle → writes `0088=AA`, `0089=BB`, `008A=CC`; `exec_addr=0200` with one `exec_valid` pulse; `error=0`.
- **256-byte segment with wrap:** segment `hi=03 lo=F0 size=00` → 256 writes from 03F0 wrapping to 0300..03EF, never 0400; a random 0–5 cycle ack delay never loses a byte and `ioctl_wait` covers every pending write.
- **Multi-segment:** first segment at page 0x00, second at 0x80, then terminator `00 12 34` → both segments written, `exec_addr=1234`.
- **Truncation and overrun:**
  - `ioctl_download` falls in DATA with 2 bytes remaining → `error=1`, no further `ram_wr_req`, no `exec_valid`.
  - An injected `ioctl_wr` during WR_WAIT → `error=1`.
- **Offset gap and index filter:**
  - An `ioctl_addr` jump from 4 to 6 → `error=1`.
  - A download with `ioctl_index≠INDEX` → no outputs toggle.
- **Reset mid-write:** `reset_n` low while `ram_wr_req=1` → all outputs 0 immediately; the next download parses cleanly from IDLE.
